// File: rtl/i2s_tx.sv
// i2s_tx: standard I2S transmitter, one mono sample duplicated into the left and right slots of each 64-bit frame.
// Latency: a sample accepted before a frame load goes out MSB first, one bclk after the next lrclk edge.
// Backpressure: one-entry holding buffer; sample_ready is low while it is full and offers are held off, never overwritten.
module i2s_tx #(
    parameter int DATA_W   = 24,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]  r_div;
    logic              r_bclk;
    logic              r_lrclk;
    logic              r_sdata;
    logic              r_underrun;
    logic              r_buf_empty;
    logic [5:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_buf;

    logic              w_div_wrap;
    logic              w_fall;
    logic              w_load;
    logic              w_accept;
    logic [5:0]        w_bit_next;
    logic [4:0]        w_pos;
    logic [5:0]        w_idx;
    logic [63:0]       w_shift_ext;
    logic              w_bit;

    // Edge detection, frame-load qualification and selection of the next serial bit.
    // The shift register is zero-extended to 64 bits so the slot index never leaves the vector.
    always_comb begin
        w_div_wrap  = (r_div == DIV_LAST);
        w_fall      = w_div_wrap && r_bclk;
        w_load      = w_fall && (r_bit_cnt == 6'd63);
        w_accept    = sample_valid && r_buf_empty;
        w_bit_next  = r_bit_cnt + 6'd1;
        w_pos       = w_bit_next[4:0];
        w_idx       = 6'(DATA_W) - {1'b0, w_pos};
        w_shift_ext = 64'(r_shift);
        w_bit       = 1'b0;
        if ((w_pos != 5'd0) && ({1'b0, w_pos} <= 6'(DATA_W))) begin
            w_bit = w_shift_ext[w_idx];
        end
    end

    // Bit-clock divider: bclk toggles each time the counter wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Serial side: bit counter, word select and data change only on falling bclk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 6'd63;
            r_lrclk   <= 1'b1;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lrclk   <= w_bit_next[5];
            r_sdata   <= w_bit;
        end
    end

    // Holding buffer and frame load; an empty buffer at load time either bypasses a
    // same-cycle offer straight into the shift register or substitutes silence and flags underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_buf       <= '0;
            r_buf_empty <= 1'b1;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                r_buf_empty <= 1'b1;
                if (!r_buf_empty) begin
                    r_shift <= r_buf;
                end else if (sample_valid) begin
                    r_shift <= sample_in;
                end else begin
                    r_shift    <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_buf       <= sample_in;
                r_buf_empty <= 1'b0;
            end
        end
    end

    assign sample_ready = r_buf_empty;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: checks i2s_tx (DATA_W=24, BCLK_DIV=2) against a time-indexed frame model and an I2S receiver.
// Latency: outputs compared every clk, 1 time unit after the rising edge.
// Backpressure: buffer occupancy is modelled from the offers the bench makes.
module tb_i2s_tx;

    localparam int DW = 24;
    localparam int D  = 2;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic [DW-1:0] sample_in    = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    i2s_tx #(.DATA_W(DW), .BCLK_DIV(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts clk edges since reset release; frame f is loaded at
    // edge 2*D*(1 + 64*f). Each loaded frame's sample and underrun flag are queued.
    int            m_t     = 0;
    logic          m_empty = 1'b1;
    logic [DW-1:0] m_buf   = '0;
    logic [DW-1:0] m_frame[$];
    logic          m_urn[$];

    function automatic bit is_load(int t);
        return (t > 0) && (t % (2 * D) == 0) && (((t / (2 * D)) - 1) % 64 == 0);
    endfunction

    always begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_t     = 0;
            m_empty = 1'b1;
            m_frame.delete();
            m_urn.delete();
        end else begin
            m_t = m_t + 1;
            if (is_load(m_t)) begin
                if (!m_empty) begin
                    m_frame.push_back(m_buf);
                    m_urn.push_back(1'b0);
                    m_empty = 1'b1;
                end else if (sample_valid) begin
                    m_frame.push_back(sample_in);
                    m_urn.push_back(1'b0);
                end else begin
                    m_frame.push_back('0);
                    m_urn.push_back(1'b1);
                end
            end else if (sample_valid && m_empty) begin
                m_buf   = sample_in;
                m_empty = 1'b0;
            end
        end
    end

    // Expected {bclk, lrclk, sdata, underrun, sample_ready} after edge m_t.
    function automatic logic [4:0] model_out();
        int k, bc, p, f;
        logic [DW-1:0] s;
        logic e_bclk, e_lr, e_sd, e_ur;
        k      = m_t / (2 * D);
        bc     = (63 + k) % 64;
        e_bclk = ((m_t / D) % 2) == 1;
        e_lr   = bc >= 32;
        p      = bc % 32;
        e_sd   = 1'b0;
        e_ur   = 1'b0;
        if (k >= 1) begin
            f = (k - 1) / 64;
            if (f < m_frame.size()) begin
                s = m_frame[f];
                if (p >= 1 && p <= DW) e_sd = s[DW - p];
                if (is_load(m_t)) e_ur = m_urn[f];
            end
        end
        return {e_bclk, e_lr, e_sd, e_ur, m_empty};
    endfunction

    // Independent I2S receiver: samples on rising bclk, slot bit 0 is the bit right after
    // an lrclk change, bits 1..DW form the word MSB first.
    int            rx_pos  = 32;
    logic          rx_prev = 1'b1;
    logic [DW-1:0] rx_acc  = '0;
    logic [DW-1:0] rx_q[$];

    always begin
        @(posedge bclk or posedge reset);
        if (reset) begin
            rx_pos  = 32;
            rx_prev = 1'b1;
            rx_q.delete();
        end else begin
            if (lrclk !== rx_prev) rx_pos = 0;
            else if (rx_pos < 32) rx_pos = rx_pos + 1;
            rx_prev = lrclk;
            if (rx_pos >= 1 && rx_pos <= DW) rx_acc = {rx_acc[DW-2:0], sdata};
            if (rx_pos == DW) rx_q.push_back(rx_acc);
        end
    end

    task automatic do_reset();
        sample_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        sample_valid = 1'b1;
        sample_in = 24'h5A5A5A;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b01001) begin
                errors++;
                $display("FAIL reset_state got %b want 01001", {bclk, lrclk, sdata, underrun, sample_ready});
            end
        end
        sample_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_sample();
        int last_rise = -1;
        int period = 0;
        logic prev_lr = 1'b1;
        logic [DW-1:0] exp_w[4] = '{24'h800001, 24'h800001, 24'h000000, 24'h000000};
        logic [DW-1:0] got;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            sample_valid = (c == 0);
            sample_in = 24'h800001;
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL single_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
            if (lrclk && !prev_lr) begin
                if (last_rise >= 0) period = m_t - last_rise;
                last_rise = m_t;
            end
            prev_lr = lrclk;
        end
        sample_valid = 1'b0;
        checks++;
        if (period !== 256) begin
            errors++;
            $display("FAIL lrclk_period got %0d want 256", period);
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin
                errors++;
                $display("FAIL single_word%0d got %h want %h", i, got, exp_w[i]);
            end
        end
    endtask

    task automatic test_no_sample();
        int n_urn = 0;
        int n_sd = 0;
        int first_urn = -1;
        int last_urn = -1;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL idle_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
            if (underrun === 1'b1) begin
                n_urn++;
                if (first_urn < 0) first_urn = m_t;
                last_urn = m_t;
            end
            if (sdata !== 1'b0) n_sd++;
        end
        checks++;
        if (n_urn !== 4) begin
            errors++;
            $display("FAIL idle_underrun_count got %0d want 4", n_urn);
        end
        checks++;
        if (last_urn - first_urn !== 768) begin
            errors++;
            $display("FAIL idle_underrun_spacing got %0d want 768", last_urn - first_urn);
        end
        checks++;
        if (n_sd !== 0) begin
            errors++;
            $display("FAIL idle_sdata_ones got %0d want 0", n_sd);
        end
    endtask

    task automatic test_load_collision();
        logic [DW-1:0] v;
        int n_urn = 0;
        int n_busy = 0;
        logic [DW-1:0] got;
        v = DW'($urandom);
        do_reset();
        for (int c = 0; c < 250; c++) begin
            sample_valid = (c == 3);
            sample_in = v;
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL collide_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
            if (underrun === 1'b1) n_urn++;
            if (sample_ready !== 1'b1) n_busy++;
        end
        sample_valid = 1'b0;
        checks++;
        if (n_urn !== 0) begin
            errors++;
            $display("FAIL collide_underrun got %0d want 0", n_urn);
        end
        checks++;
        if (n_busy !== 0) begin
            errors++;
            $display("FAIL collide_ready_low got %0d want 0", n_busy);
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 'x;
            checks++;
            if (got !== v) begin
                errors++;
                $display("FAIL collide_word%0d got %h want %h", i, got, v);
            end
        end
    endtask

    task automatic test_full_ignore();
        int n_rdy = 0;
        int n_urn = 0;
        logic [DW-1:0] exp_w[4] = '{24'h000000, 24'h000000, 24'h123456, 24'h123456};
        logic [DW-1:0] got;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            sample_valid = (c >= 10 && c < 200);
            sample_in = (c == 10) ? 24'h123456 : 24'hABCDEF;
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL full_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
            if (m_t >= 11 && m_t < 260 && sample_ready !== 1'b0) n_rdy++;
            if (underrun === 1'b1) n_urn++;
        end
        sample_valid = 1'b0;
        checks++;
        if (n_rdy !== 0) begin
            errors++;
            $display("FAIL full_ready_high got %0d want 0", n_rdy);
        end
        checks++;
        if (n_urn !== 1) begin
            errors++;
            $display("FAIL full_underrun_count got %0d want 1", n_urn);
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin
                errors++;
                $display("FAIL full_word%0d got %h want %h", i, got, exp_w[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 166; c++) begin
            sample_valid = (c == 0 || c == 10);
            sample_in = (c == 0) ? 24'hC0FFEE : 24'h0BEEF1;
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL midrst_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
        end
        sample_valid = 1'b0;
        checks++;
        if ({bclk, lrclk, sample_ready} !== 3'b110) begin
            errors++;
            $display("FAIL midrst_before got %b want 110", {bclk, lrclk, sample_ready});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b01001) begin
            errors++;
            $display("FAIL midrst_immediate got %b want 01001", {bclk, lrclk, sdata, underrun, sample_ready});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL midrst_restart t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
            if (m_t == 2) begin
                checks++;
                if (bclk !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_bclk_rise got %b want 1", bclk);
                end
            end
            if (m_t == 4) begin
                checks++;
                if ({lrclk, underrun, sample_ready} !== 3'b011) begin
                    errors++;
                    $display("FAIL midrst_first_load got %b want 011", {lrclk, underrun, sample_ready});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_urn = 0;
        logic [DW-1:0] exp_w[4] = '{24'h7FFFFF, 24'h7FFFFF, 24'h000000, 24'h000000};
        logic [DW-1:0] got;
        do_reset();
        for (int c = 0; c < 515; c++) begin
            sample_valid = (c == 0 || c == 20);
            sample_in = (c == 0) ? 24'h7FFFFF : 24'h000000;
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL b2b_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
            if (underrun === 1'b1) n_urn++;
        end
        sample_valid = 1'b0;
        checks++;
        if (n_urn !== 0) begin
            errors++;
            $display("FAIL b2b_underrun got %0d want 0", n_urn);
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h want %h", i, got, exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 799) == 0);
            sample_valid = ($urandom_range(0, 255) < 3);
            sample_in = DW'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({bclk, lrclk, sdata, underrun, sample_ready} !== model_out()) begin
                errors++;
                $display("FAIL random_stream t=%0d got %b want %b", m_t, {bclk, lrclk, sdata, underrun, sample_ready}, model_out());
            end
        end
        reset = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_no_sample();
        test_load_collision();
        test_full_ignore();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
